wb_delay_bridge: RTL and testbench

- Parametrised Wishbone slave-to-master bridge that inserts a programmable, fixed or pseudo-random delay before each transfer reaches the downstream memory (BRAM, data RAM).
- Sits between a CPU bus port and a memory slave to stress pipeline stall handling.
- Adds three delay modes, abort handling and a stall-cycle counter.
- Handshake is a registered FSM; it does not gate cyc/stb/ack combinationally.

---
 rtl/wb_delay_bridge.sv | 162 ++++++++++++++++
 tb/tb_wb_delay_bridge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_delay_bridge.sv
// Wishbone bridge that holds each request for none, a fixed or an LFSR-drawn
// number of cycles before issuing it to the downstream slave.
module wb_delay_bridge #(
   parameter int          ADDR_W    = 32,
   parameter int          DATA_W    = 32,
   parameter int          SEL_W     = DATA_W / 8,
   parameter int          DELAY_W   = 4,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic [1:0]         cfg_mode_i,
   input  logic [DELAY_W-1:0] cfg_delay_i,
   input  logic               wb_cyc_i,
   input  logic               wb_stb_i,
   input  logic               wb_we_i,
   input  logic [ADDR_W-1:0]  wb_adr_i,
   input  logic [DATA_W-1:0]  wb_dat_i,
   input  logic [SEL_W-1:0]   wb_sel_i,
   output logic [DATA_W-1:0]  wb_dat_o,
   output logic               wb_ack_o,
   output logic               m_cyc_o,
   output logic               m_stb_o,
   output logic               m_we_o,
   output logic [ADDR_W-1:0]  m_adr_o,
   output logic [DATA_W-1:0]  m_dat_o,
   output logic [SEL_W-1:0]   m_sel_o,
   input  logic [DATA_W-1:0]  m_dat_i,
   input  logic               m_ack_i,
   output logic [31:0]        stall_cnt_o
);
   localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   typedef enum logic [1:0] {IDLE, WAIT, ISSUE, RESP} state_t;

   state_t             state_q, state_d;
   logic [DELAY_W-1:0] cnt_q, cnt_d;
   logic [DELAY_W-1:0] delay_req;
   logic [15:0]        lfsr_q;
   logic               abort_q, abort_d;
   logic               ack_d, cyc_d, stb_d, we_d;
   logic [ADDR_W-1:0]  adr_d;
   logic [DATA_W-1:0]  wdat_d, rdat_d;
   logic [SEL_W-1:0]   sel_d;
   logic [31:0]        stall_d;

   function automatic logic [DELAY_W-1:0] pick_delay(input logic [1:0]         mode,
                                                     input logic [DELAY_W-1:0] cfg,
                                                     input logic [DELAY_W-1:0] rnd);
      case (mode)
         2'd0:    pick_delay = '0;
         2'd2:    pick_delay = rnd & cfg;
         default: pick_delay = cfg;
      endcase
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   assign delay_req = pick_delay(cfg_mode_i, cfg_delay_i, lfsr_q[DELAY_W-1:0]);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) lfsr_q <= SEED;
      else          lfsr_q <= lfsr_step(lfsr_q);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      abort_d = abort_q;
      ack_d   = 1'b0;
      cyc_d   = m_cyc_o;
      stb_d   = m_stb_o;
      we_d    = m_we_o;
      adr_d   = m_adr_o;
      wdat_d  = m_dat_o;
      sel_d   = m_sel_o;
      rdat_d  = wb_dat_o;
      stall_d = stall_cnt_o;
      case (state_q)
         IDLE: begin
            abort_d = 1'b0;
            if (wb_cyc_i && wb_stb_i) begin
               we_d   = wb_we_i;
               adr_d  = wb_adr_i;
               wdat_d = wb_dat_i;
               sel_d  = wb_sel_i;
               if (delay_req == '0) begin
                  state_d = ISSUE;
                  cyc_d   = 1'b1;
                  stb_d   = 1'b1;
               end else begin
                  cnt_d   = delay_req;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!wb_cyc_i) begin
               // Master walked away before anything reached the slave.
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               stall_d = sat_inc(stall_cnt_o);
               cnt_d   = cnt_q - 1'b1;
               if (cnt_q == DELAY_W'(1)) begin
                  state_d = ISSUE;
                  cyc_d   = 1'b1;
                  stb_d   = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (!wb_cyc_i) abort_d = 1'b1;
            if (m_ack_i) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               if (!m_we_o) rdat_d = m_dat_i;
               ack_d   = !abort_q && wb_cyc_i;
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         abort_q     <= 1'b0;
         wb_ack_o    <= 1'b0;
         m_cyc_o     <= 1'b0;
         m_stb_o     <= 1'b0;
         m_we_o      <= 1'b0;
         m_adr_o     <= '0;
         m_dat_o     <= '0;
         m_sel_o     <= '0;
         wb_dat_o    <= '0;
         stall_cnt_o <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         abort_q     <= abort_d;
         wb_ack_o    <= ack_d;
         m_cyc_o     <= cyc_d;
         m_stb_o     <= stb_d;
         m_we_o      <= we_d;
         m_adr_o     <= adr_d;
         m_dat_o     <= wdat_d;
         m_sel_o     <= sel_d;
         wb_dat_o    <= rdat_d;
         stall_cnt_o <= stall_d;
      end
   end
endmodule

// File: tb/tb_wb_delay_bridge.sv
// Directed and randomized bench for wb_delay_bridge with a memory-backed
// downstream slave and a spec-level reference for delays, data and stalls.
module tb_wb_delay_bridge;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  cfg_mode = 2'd0;
   logic [3:0]  cfg_delay = 4'd0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [31:0] adr = 32'h0, wdat = 32'h0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] wb_dat_o, m_adr_o, m_dat_o, m_dat_i, stall_cnt_o;
   logic        wb_ack_o, m_cyc_o, m_stb_o, m_we_o, m_ack_i;
   logic [3:0]  m_sel_o;

   int nvec = 0;
   int nerr = 0;
   int ncyc = 0;
   int slave_k = 0;
   int s_cnt = 0;

   bit [31:0] smem [256];
   bit        swr  [256];
   bit [31:0] exp_mem [256];
   bit        exp_wr  [256];

   wb_delay_bridge dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .cfg_mode_i(cfg_mode), .cfg_delay_i(cfg_delay),
      .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(wdat),
      .wb_sel_i(sel), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .m_cyc_o(m_cyc_o),
      .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
      .m_sel_o(m_sel_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk = ~clk;

   // Edges since reset release; the LFSR value in any cycle is seed stepped this many times.
   always @(posedge clk or posedge rst) begin
      if (rst) ncyc <= 0;
      else     ncyc <= ncyc + 1;
   end

   function automatic logic [31:0] def_data(input logic [7:0] a);
      return (a == 8'h10) ? 32'hDEADBEEF : {8'h5A, a, ~a, 8'hC3};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // Downstream slave: acks slave_k cycles after stb rises, byte-lane writes.
   wire [7:0] s_a = m_adr_o[7:0];
   assign m_dat_i = swr[s_a] ? smem[s_a] : def_data(s_a);
   assign m_ack_i = m_cyc_o && m_stb_o && (s_cnt >= slave_k);

   always @(posedge clk or posedge rst) begin
      if (rst) s_cnt <= 0;
      else begin
         if (m_cyc_o && m_stb_o && !m_ack_i) s_cnt <= s_cnt + 1;
         else                                s_cnt <= 0;
         if (m_cyc_o && m_stb_o && m_ack_i && m_we_o) begin
            smem[s_a] <= merge(m_dat_i, m_dat_o, m_sel_o);
            swr[s_a]  <= 1'b1;
         end
      end
   end

   function automatic logic [15:0] lfsr_at(input int n);
      logic [15:0] v;
      v = 16'hACE1;
      for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
      return v;
   endfunction

   function automatic int expected_delay(input logic [1:0] mode, input logic [3:0] mask);
      logic [15:0] l;
      l = lfsr_at(ncyc);
      if (mode == 2'd0) return 0;
      if (mode == 2'd2) return int'(l[3:0] & mask);
      return int'(mask);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      nvec++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic run_txn(input logic t_we, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int k, output int got_d);
      int n, m, expd;
      logic [31:0] stall0, dat0, exp_rd;
      stall0 = stall_cnt_o;
      dat0   = wb_dat_o;
      exp_rd = exp_wr[a] ? exp_mem[a] : def_data(a);
      expd   = expected_delay(cfg_mode, cfg_delay);
      got_d  = expd;
      slave_k = k;
      cyc = 1'b1; stb = 1'b1; we = t_we; adr = {24'h0, a}; wdat = d; sel = s;
      n = 0;
      do begin tick(); n++; end while (!m_stb_o && n < 64);
      chk("stb_latency", 64'(n), 64'(expd + 1));
      chk("m_cyc", 64'(m_cyc_o), 64'd1);
      chk("m_we", 64'(m_we_o), 64'(t_we));
      chk("m_adr", 64'(m_adr_o), {32'h0, 24'h0, a});
      chk("m_dat", 64'(m_dat_o), 64'(d));
      chk("m_sel", 64'(m_sel_o), 64'(s));
      m = 0;
      while (!wb_ack_o && m < 64) begin tick(); m++; end
      chk("ack_latency", 64'(n + m), 64'(expd + k + 2));
      chk("rd_data", 64'(wb_dat_o), 64'(t_we ? dat0 : exp_rd));
      chk("stall", 64'(stall_cnt_o), 64'(stall0 + 32'(expd)));
      if (t_we) begin
         exp_mem[a] = merge(exp_rd, d, s);
         exp_wr[a]  = 1'b1;
      end
      cyc = 1'b0; stb = 1'b0;
      tick();
      chk("ack_pulse", 64'(wb_ack_o), 64'd0);
      chk("m_cyc_drop", 64'(m_cyc_o), 64'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ack"}, 64'(wb_ack_o), 64'd0);
      chk({tag, "_mcyc"}, 64'(m_cyc_o), 64'd0);
      chk({tag, "_mstb"}, 64'(m_stb_o), 64'd0);
      chk({tag, "_mwe"}, 64'(m_we_o), 64'd0);
      chk({tag, "_wbdat"}, 64'(wb_dat_o), 64'd0);
      chk({tag, "_madr"}, 64'(m_adr_o), 64'd0);
      chk({tag, "_mdat"}, 64'(m_dat_o), 64'd0);
      chk({tag, "_msel"}, 64'(m_sel_o), 64'd0);
      chk({tag, "_stall"}, 64'(stall_cnt_o), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dd, nm, distinct;
      logic [31:0] st0, rv;
      logic saw_mcyc, saw_ack;
      bit seen [16];

      #1 rst = 1'b1;
      #1 chk_reset_outputs("reset");
      tick();
      @(posedge clk);
      #3 rst = 1'b0;
      tick();

      // Mode 0 read of the preloaded word.
      cfg_mode = 2'd0;
      run_txn(1'b0, 8'h10, 32'h0, 4'hF, 0, dd);

      // Fixed delay 5 write.
      cfg_mode = 2'd1; cfg_delay = 4'd5;
      run_txn(1'b1, 8'h20, 32'h12345678, 4'hF, 0, dd);
      chk("wr_kept_dat", 64'(wb_dat_o), 64'h0000_0000_DEADBEEF);
      chk("stall_after_d5", 64'(stall_cnt_o), 64'd5);
      run_txn(1'b0, 8'h20, 32'h0, 4'hF, 1, dd);

      // Random fixed-delay traffic, mode 3 aliases mode 1, partial byte writes.
      for (int i = 0; i < 12; i++) begin
         cfg_mode  = (i % 2 == 0) ? 2'd1 : 2'd3;
         cfg_delay = 4'($urandom_range(1, 15));
         run_txn(1'($urandom_range(0, 1)), 8'(8'h80 | 8'($urandom_range(0, 15))),
                 $urandom, 4'($urandom_range(1, 15)), int'($urandom_range(0, 3)), dd);
      end

      // Random mode with zero mask never stalls.
      cfg_mode = 2'd2; cfg_delay = 4'h0;
      st0 = stall_cnt_o;
      for (int i = 0; i < 100; i++)
         run_txn(1'b0, 8'(8'h80 | 8'($urandom_range(0, 15))), 32'h0, 4'hF, 0, dd);
      chk("mask0_stall", 64'(stall_cnt_o), 64'(st0));

      // Random mode with full mask draws from the LFSR.
      cfg_delay = 4'hF;
      for (int i = 0; i < 16; i++) seen[i] = 1'b0;
      for (int i = 0; i < 100; i++) begin
         run_txn(1'b0, 8'(8'h80 | 8'($urandom_range(0, 15))), 32'h0, 4'hF,
                 int'($urandom_range(0, 2)), dd);
         seen[dd[3:0]] = 1'b1;
      end
      distinct = 0;
      for (int i = 0; i < 16; i++) if (seen[i]) distinct++;
      chk("distinct_ge8", 64'(distinct >= 8), 64'd1);

      // Abort during WAIT after three stall cycles.
      cfg_mode = 2'd1; cfg_delay = 4'd8;
      st0 = stall_cnt_o; saw_mcyc = 1'b0; saw_ack = 1'b0;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h30;
      for (int i = 0; i < 4; i++) begin
         tick();
         saw_mcyc |= m_cyc_o; saw_ack |= wb_ack_o;
      end
      cyc = 1'b0; stb = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         saw_mcyc |= m_cyc_o; saw_ack |= wb_ack_o;
      end
      chk("wabort_mcyc", 64'(saw_mcyc), 64'd0);
      chk("wabort_ack", 64'(saw_ack), 64'd0);
      chk("wabort_stall", 64'(stall_cnt_o - st0), 64'd3);
      cfg_delay = 4'd2;
      run_txn(1'b0, 8'h30, 32'h0, 4'hF, 0, dd);

      // Abort during ISSUE with a slow slave.
      cfg_mode = 2'd0; slave_k = 3;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h44;
      tick();
      chk("iabort_stb", 64'(m_stb_o), 64'd1);
      cyc = 1'b0; stb = 1'b0;
      nm = 0; saw_ack = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (m_ack_i) nm++;
         saw_ack |= wb_ack_o;
      end
      chk("iabort_mack", 64'(nm), 64'd1);
      chk("iabort_ack", 64'(saw_ack), 64'd0);
      chk("iabort_mcyc", 64'(m_cyc_o), 64'd0);
      run_txn(1'b0, 8'h44, 32'h0, 4'hF, 2, dd);

      // Asynchronous reset in the middle of WAIT.
      cfg_mode = 2'd1; cfg_delay = 4'd8;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h50;
      tick();
      tick();
      #2 rst = 1'b1;
      cyc = 1'b0; stb = 1'b0;
      #1 chk_reset_outputs("async_rst");
      @(posedge clk);
      #3 rst = 1'b0;
      tick();
      cfg_mode = 2'd0;
      run_txn(1'b0, 8'h10, 32'h0, 4'hF, 0, dd);
      chk("post_rst_stall", 64'(stall_cnt_o), 64'd0);
      rv = wb_dat_o;
      chk("post_rst_dat", 64'(rv), 64'h0000_0000_DEADBEEF);
      cfg_mode = 2'd2; cfg_delay = 4'hF;
      for (int i = 0; i < 6; i++)
         run_txn(1'b0, 8'(8'h80 | 8'($urandom_range(0, 15))), 32'h0, 4'hF, 0, dd);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
